// File: rtl/pps_monitor.sv
`default_nettype none
// ============================================================================
// pps_monitor : synchronizes a PPS input, measures edge-to-edge period and
//               reports period qualification, lock and loss-of-signal status.
// Revision    : 1.0
// ============================================================================
module pps_monitor #(
  parameter logic [31:0] CLK_FREQ   = 32'd10_000_000,
  parameter logic [31:0] TOLERANCE  = 32'd100,
  parameter logic [3:0]  LOCK_COUNT = 4'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pps_in,
  output logic        pps_edge,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        period_good,
  output logic        locked,
  output logic        lost,
  output logic [31:0] edge_count
);

  localparam logic [32:0] c_TIMEOUT = {1'b0, CLK_FREQ} + {1'b0, TOLERANCE} + 33'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic [1:0]         r_rst_sync;
  logic               w_run;
  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic               w_edge;
  logic [31:0]        r_cnt;
  logic signed [32:0] w_diff;
  logic [32:0]        w_abs;
  logic               w_good;
  logic               w_timeout;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_good_cnt;
  logic [3:0]         w_good_cnt_nxt;
  logic [4:0]         w_good_inc;
  logic               r_pps_edge;
  logic [31:0]        r_period;
  logic [31:0]        w_period_nxt;
  logic               r_period_valid;
  logic               w_period_valid_nxt;
  logic               r_period_good;
  logic               w_period_good_nxt;
  logic               r_locked;
  logic               w_locked_nxt;
  logic               r_lost;
  logic               w_lost_nxt;
  logic [31:0]        r_edge_count;

  // Reset release is synchronized; assertion stays asynchronous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (!w_run) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pps_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 32'd0;
    end else if (!w_run) begin
      r_cnt <= 32'd0;
    end else if (w_edge) begin
      r_cnt <= 32'd1;
    end else if (r_cnt != 32'hFFFF_FFFF) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // 33-bit signed difference so periods far below CLK_FREQ cannot wrap.
  assign w_diff    = $signed({1'b0, r_cnt}) - $signed({1'b0, CLK_FREQ});
  assign w_abs     = w_diff[32] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_good    = (w_abs <= {1'b0, TOLERANCE});
  assign w_timeout = ({1'b0, r_cnt} == c_TIMEOUT);

  always_comb begin
    w_state_nxt        = r_state;
    w_good_cnt_nxt     = r_good_cnt;
    w_good_inc         = {1'b0, r_good_cnt} + 5'd1;
    w_period_nxt       = r_period;
    w_period_valid_nxt = 1'b0;
    w_period_good_nxt  = r_period_good;
    w_locked_nxt       = r_locked;
    w_lost_nxt         = r_lost;
    if (w_edge) begin
      w_lost_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_MEASURE;
        end
        ST_MEASURE, ST_LOCKED: begin
          w_period_nxt       = r_cnt;
          w_period_valid_nxt = 1'b1;
          w_period_good_nxt  = w_good;
          if (w_good) begin
            if (r_state == ST_MEASURE) begin
              w_good_cnt_nxt = w_good_inc[3:0];
              if (w_good_inc >= {1'b0, LOCK_COUNT}) begin
                w_state_nxt  = ST_LOCKED;
                w_locked_nxt = 1'b1;
              end
            end
          end else begin
            w_good_cnt_nxt = 4'd0;
            w_locked_nxt   = 1'b0;
            w_state_nxt    = ST_MEASURE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else if ((r_state != ST_IDLE) && w_timeout) begin
      w_lost_nxt     = 1'b1;
      w_locked_nxt   = 1'b0;
      w_good_cnt_nxt = 4'd0;
      w_state_nxt    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_good_cnt     <= 4'd0;
      r_pps_edge     <= 1'b0;
      r_period       <= 32'd0;
      r_period_valid <= 1'b0;
      r_period_good  <= 1'b0;
      r_locked       <= 1'b0;
      r_lost         <= 1'b0;
      r_edge_count   <= 32'd0;
    end else if (!w_run) begin
      r_state        <= ST_IDLE;
      r_good_cnt     <= 4'd0;
      r_pps_edge     <= 1'b0;
      r_period       <= 32'd0;
      r_period_valid <= 1'b0;
      r_period_good  <= 1'b0;
      r_locked       <= 1'b0;
      r_lost         <= 1'b0;
      r_edge_count   <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_good_cnt     <= w_good_cnt_nxt;
      r_pps_edge     <= w_edge;
      r_period       <= w_period_nxt;
      r_period_valid <= w_period_valid_nxt;
      r_period_good  <= w_period_good_nxt;
      r_locked       <= w_locked_nxt;
      r_lost         <= w_lost_nxt;
      if (w_edge) begin
        r_edge_count <= r_edge_count + 32'd1;
      end
    end
  end

  assign pps_edge     = r_pps_edge;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign period_good  = r_period_good;
  assign locked       = r_locked;
  assign lost         = r_lost;
  assign edge_count   = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_pps_monitor.sv
`default_nettype none
// tb_pps_monitor : PPS stimulus (directed + $urandom intervals) checked every
// cycle against an event-level model working on edge timestamps.
module tb_pps_monitor;

  localparam int c_F = 1000;
  localparam int c_T = 2;
  localparam int c_L = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pps_in = 1'b0;
  logic        pps_edge;
  logic [31:0] period;
  logic        period_valid;
  logic        period_good;
  logic        locked;
  logic        lost;
  logic [31:0] edge_count;

  pps_monitor #(
    .CLK_FREQ   (32'd1000),
    .TOLERANCE  (32'd2),
    .LOCK_COUNT (4'd3)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pps_in       (pps_in),
    .pps_edge     (pps_edge),
    .period       (period),
    .period_valid (period_valid),
    .period_good  (period_good),
    .locked       (locked),
    .lost         (lost),
    .edge_count   (edge_count)
  );

  initial forever #5 clk = ~clk;

  longint      cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  // Model: 0 = no reference, 1 = measuring, 2 = locked.
  int          m_mode;
  longint      m_last;
  int          m_run;
  int          m_hold;
  logic [3:0]  m_hist;
  logic [31:0] m_ecount;
  logic [31:0] m_period;
  logic        m_pgood;
  logic        m_locked;
  logic        m_lost;
  logic        m_edge;
  logic        m_pv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_mode   = 0;
    m_last   = 0;
    m_run    = 0;
    m_hist   = 4'b0000;
    m_ecount = 32'd0;
    m_period = 32'd0;
    m_pgood  = 1'b0;
    m_locked = 1'b0;
    m_lost   = 1'b0;
    m_edge   = 1'b0;
    m_pv     = 1'b0;
  endfunction

  task automatic check_all();
    chk("pps_edge",     {31'd0, pps_edge},     {31'd0, m_edge});
    chk("period_valid", {31'd0, period_valid}, {31'd0, m_pv});
    chk("period",       period,                m_period);
    chk("period_good",  {31'd0, period_good},  {31'd0, m_pgood});
    chk("locked",       {31'd0, locked},       {31'd0, m_locked});
    chk("lost",         {31'd0, lost},         {31'd0, m_lost});
    chk("edge_count",   edge_count,            m_ecount);
  endtask

  task automatic tick();
    logic   smp;
    longint per;
    smp = pps_in;
    @(posedge clk);
    #1;
    cyc++;
    m_edge = 1'b0;
    m_pv   = 1'b0;
    if (!reset_n || m_hold > 0) begin
      if (reset_n) m_hold--;
      else m_hold = 2;
      model_reset();
    end else begin
      m_hist = {m_hist[2:0], smp};
      if (m_hist[2] && !m_hist[3]) begin
        m_edge   = 1'b1;
        m_ecount = m_ecount + 32'd1;
        m_lost   = 1'b0;
        if (m_mode == 0) begin
          m_mode = 1;
        end else begin
          per      = cyc - m_last;
          m_pv     = 1'b1;
          m_period = 32'(per);
          m_pgood  = (per >= c_F - c_T) && (per <= c_F + c_T);
          if (m_pgood) begin
            m_run++;
            if (m_mode == 1 && m_run >= c_L) begin
              m_mode   = 2;
              m_locked = 1'b1;
            end
          end else begin
            m_run    = 0;
            m_mode   = 1;
            m_locked = 1'b0;
          end
        end
        m_last = cyc;
      end else if (m_mode != 0 && (cyc - m_last) == c_F + c_T + 1) begin
        m_lost   = 1'b1;
        m_locked = 1'b0;
        m_run    = 0;
        m_mode   = 0;
      end
    end
    check_all();
  endtask

  task automatic pulse(input int len, input int high);
    for (int i = 0; i < len; i++) begin
      pps_in = (i < high);
      tick();
    end
  endtask

  task automatic quiet(input int n);
    pps_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int r;
    int len;
    model_reset();
    m_hold  = 2;
    reset_n = 1'b0;
    pps_in  = 1'b0;
    quiet(4);
    reset_n = 1'b1;
    quiet(20);

    // Acquire lock, one bad period, relock, inclusive tolerance boundaries.
    repeat (5) pulse(1000, 250);
    pulse(1003, 250);
    repeat (4) pulse(1000, 250);
    pulse(998, 100);
    pulse(1002, 300);
    pulse(1000, 250);

    // Signal stops while locked, then returns.
    quiet(1500);
    repeat (3) pulse(1000, 250);

    repeat (18) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      len = 998 + int'($urandom_range(0, 4));
      else if (r == 6) len = 1003;
      else if (r == 7) len = 997;
      else if (r == 8) len = int'($urandom_range(500, 1500));
      else             len = 1000;
      pulse(len, int'($urandom_range(2, 400)));
    end

    // Asynchronous reset mid-period while locked.
    repeat (5) pulse(1000, 250);
    pps_in = 1'b1;
    repeat (250) tick();
    pps_in = 1'b0;
    repeat (150) tick();
    #2;
    reset_n = 1'b0;
    #1;
    m_edge = 1'b0;
    m_pv   = 1'b0;
    model_reset();
    m_hold = 2;
    check_all();
    repeat (3) tick();
    reset_n = 1'b1;
    quiet(10);
    repeat (4) pulse(1000, 250);

    // Level held high: one edge only, then loss of signal.
    pps_in = 1'b1;
    repeat (5000) tick();
    quiet(10);
    repeat (3) pulse(1000, 250);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
